// File: rtl/hub75_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hub75_pkg : scan state encoding and derived-width helpers for HUB75 scan  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_BLANK     = 3'd4,
    S_DISPLAY   = 3'd5
  } scan_state_t;

  // Never returns 0 so that degenerate parameter sets still give legal vectors.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int calc_rows(input int vpixel, input int segments);
    return vpixel / segments;
  endfunction

  localparam int rows_p = calc_rows(64, 2);
  localparam int row_w  = clog2_min1(rows_p);
  localparam int addr_w = clog2_min1(64 * 64);
  localparam int bit_w  = clog2_min1(8);

endpackage
`default_nettype wire

// File: rtl/hub75_oe_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hub75_oe_timer : loadable down-counter timing the OE-active window        |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module hub75_oe_timer #(
  parameter int bit_w_p = 3,
  parameter int cnt_w_p = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [7:0]         i_base,
  input  logic [bit_w_p-1:0] i_bit,
  output logic               o_done
);

  logic [cnt_w_p-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= cnt_w_p'(i_base) << i_bit;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Asserted during the final lit cycle so the FSM leaves DISPLAY on the next edge.
  assign o_done = (r_cnt == cnt_w_p'(1));

endmodule
`default_nettype wire

// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hub75_scan_ctrl : HUB75 row/bit-plane scan sequencer with BCM OE timing   |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter  int hpixel_p   = 64,
  parameter  int vpixel_p   = 64,
  parameter  int bpp_p      = 8,
  parameter  int segments_p = 2,
  parameter  int blank_p    = 2,
  localparam int c_rows     = calc_rows(vpixel_p, segments_p),
  localparam int c_row_w    = clog2_min1(c_rows),
  localparam int c_addr_w   = clog2_min1(hpixel_p * vpixel_p),
  localparam int c_bit_w    = clog2_min1(bpp_p)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_enable,
  input  logic [7:0]          i_base_time,
  input  logic                i_tx_ready,
  output logic                o_tx_start,
  output logic [c_addr_w-1:0] o_init_addr,
  output logic [c_bit_w-1:0]  o_pix_bit,
  output logic [c_row_w-1:0]  o_row_addr,
  output logic                o_oe_n,
  output logic                o_frame_done,
  output logic                o_busy
);

  localparam int c_cnt_w   = 8 + bpp_p - 1;
  localparam int c_blank_w = clog2_min1(blank_p);
  localparam logic [c_bit_w-1:0]   c_last_bit   = c_bit_w'(bpp_p - 1);
  localparam logic [c_row_w-1:0]   c_last_row   = c_row_w'(c_rows - 1);
  localparam logic [c_blank_w-1:0] c_last_blank = c_blank_w'(blank_p - 1);

  scan_state_t          r_state;
  scan_state_t          w_state_nxt;
  logic [7:0]           r_base;
  logic [c_row_w-1:0]   r_row;
  logic [c_bit_w-1:0]   r_bit;
  logic [c_blank_w-1:0] r_blank_cnt;
  logic [c_addr_w-1:0]  r_init_addr;
  logic [c_bit_w-1:0]   r_pix_bit;
  logic [c_row_w-1:0]   r_row_addr;
  logic                 r_frame_done;
  logic [7:0]           w_base_eff;
  logic                 w_oe_done;
  logic                 w_timer_load;
  logic                 w_last_bit;
  logic                 w_last_row;

  assign w_base_eff = (i_base_time == 8'd0) ? 8'd1 : i_base_time;
  assign w_last_bit = (r_bit == c_last_bit);
  assign w_last_row = (r_row == c_last_row);

  hub75_oe_timer #(
    .bit_w_p (c_bit_w),
    .cnt_w_p (c_cnt_w)
  ) u_oe_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_timer_load),
    .i_base (r_base),
    .i_bit  (r_bit),
    .o_done (w_oe_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (i_enable && i_tx_ready) w_state_nxt = S_START;
      // Unconditional: a ready-low coinciding with the start pulse is not an ack.
      S_START:     w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (!i_tx_ready) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (i_tx_ready) w_state_nxt = S_BLANK;
      S_BLANK:     if (r_blank_cnt == c_last_blank) w_state_nxt = S_DISPLAY;
      S_DISPLAY: begin
        if (w_oe_done) begin
          if (w_last_bit && w_last_row && !i_enable) w_state_nxt = S_IDLE;
          else                                       w_state_nxt = S_START;
        end
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_start   = (r_state == S_START);
    o_oe_n       = (r_state != S_DISPLAY);
    o_busy       = (r_state != S_IDLE);
    w_timer_load = (r_state == S_BLANK) && (r_blank_cnt == c_last_blank);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_row        <= '0;
      r_bit        <= '0;
      r_blank_cnt  <= '0;
      r_init_addr  <= '0;
      r_pix_bit    <= '0;
      r_row_addr   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_blank_cnt  <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_enable && i_tx_ready) begin
            r_base      <= w_base_eff;
            r_row       <= '0;
            r_bit       <= '0;
            r_init_addr <= '0;
            r_pix_bit   <= '0;
          end
        end
        S_WAIT_DONE: if (i_tx_ready) r_row_addr <= r_row;
        S_BLANK:     if (r_blank_cnt != c_last_blank) r_blank_cnt <= r_blank_cnt + 1'b1;
        S_DISPLAY: begin
          if (w_oe_done) begin
            if (!w_last_bit) begin
              r_bit     <= r_bit + 1'b1;
              r_pix_bit <= r_bit + 1'b1;
            end else begin
              r_bit     <= '0;
              r_pix_bit <= '0;
              if (w_last_row) begin
                r_row        <= '0;
                r_init_addr  <= '0;
                r_frame_done <= 1'b1;
                if (i_enable) r_base <= w_base_eff;
              end else begin
                r_row       <= r_row + 1'b1;
                r_init_addr <= r_init_addr + c_addr_w'(hpixel_p);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_init_addr  = r_init_addr;
  assign o_pix_bit    = r_pix_bit;
  assign o_row_addr   = r_row_addr;
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hub75_scan_ctrl : scoreboard bench for the HUB75 scan controller       |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_hub75_scan_ctrl;

  localparam int c_hpix  = 64;
  localparam int c_rows  = 32;
  localparam int c_bpp   = 8;
  localparam int c_blank = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [7:0]  i_base_time = 8'd4;
  logic        i_tx_ready = 1'b1;
  logic        o_tx_start;
  logic [11:0] o_init_addr;
  logic [2:0]  o_pix_bit;
  logic [4:0]  o_row_addr;
  logic        o_oe_n;
  logic        o_frame_done;
  logic        o_busy;

  always #5 clk = ~clk;

  hub75_scan_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_base_time  (i_base_time),
    .i_tx_ready   (i_tx_ready),
    .o_tx_start   (o_tx_start),
    .o_init_addr  (o_init_addr),
    .o_pix_bit    (o_pix_bit),
    .o_row_addr   (o_row_addr),
    .o_oe_n       (o_oe_n),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  typedef struct {
    int addr;
    int bitp;
    int row;
    int oe_len;
    int last;
  } slot_t;

  slot_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One expected scan slot per (row, bit plane); zero base behaves as one.
  task automatic push_frame(input int base);
    int eff;
    eff = (base == 0) ? 1 : base;
    for (int r = 0; r < c_rows; r++) begin
      for (int b = 0; b < c_bpp; b++) begin
        q.push_back('{r * c_hpix, b, r, eff << b,
                      ((r == c_rows - 1) && (b == c_bpp - 1)) ? 1 : 0});
      end
    end
  endtask

  // Transmitter: ready falls one cycle after the start pulse, rises 20 cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (o_tx_start) begin
        @(posedge clk);
        #1 i_tx_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 i_tx_ready = 1'b1;
      end
    end
  end

  task automatic wait_start(output slot_t e);
    int n;
    e = q.pop_front();
    n = 0;
    while (!o_tx_start && n < 300) begin
      step();
      n++;
    end
    check("tx_start_seen", int'(o_tx_start), 1);
    check("init_addr", int'(o_init_addr), e.addr);
    check("pix_bit", int'(o_pix_bit), e.bitp);
    step();
    check("tx_start_width", int'(o_tx_start), 0);
    check("frame_done_low", int'(o_frame_done), 0);
  endtask

  // Counts ready-high samples between the transmitter finishing and OE going low.
  task automatic wait_oe(input slot_t e);
    int n;
    int gap;
    bit acked;
    n = 0;
    gap = 0;
    acked = 1'b0;
    while (o_oe_n && n < 300) begin
      if (!i_tx_ready) acked = 1'b1;
      else if (acked) gap++;
      step();
      n++;
    end
    check("oe_seen", int'(o_oe_n), 0);
    check("blank_gap", gap, c_blank + 1);
    check("row_addr", int'(o_row_addr), e.row);
  endtask

  task automatic run_slot();
    slot_t      e;
    int         len;
    bit         moved;
    logic [4:0] ra;
    wait_start(e);
    wait_oe(e);
    ra = o_row_addr;
    moved = 1'b0;
    len = 0;
    while (!o_oe_n && len < 40000) begin
      if (o_row_addr != ra) moved = 1'b1;
      step();
      len++;
    end
    check("oe_len", len, e.oe_len);
    check("row_stable", int'(moved), 0);
    check("frame_done", int'(o_frame_done), e.last);
  endtask

  initial begin
    slot_t e;
    bit    saw_start;

    i_enable = 1'b1;
    repeat (3) step();
    check("rst_tx_start", int'(o_tx_start), 0);
    check("rst_oe_n", int'(o_oe_n), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_init_addr", int'(o_init_addr), 0);
    check("rst_frame_done", int'(o_frame_done), 0);
    rst_n = 1'b1;

    // Frame 1 at base 4; base changed to 1 mid-frame only takes effect in frame 2.
    push_frame(4);
    push_frame(1);
    for (int s = 0; s < 2 * c_rows * c_bpp; s++) begin
      run_slot();
      if (s == 3 * c_bpp) i_base_time = 8'd1;
      if (s == c_rows * c_bpp + 10 * c_bpp) i_enable = 1'b0;
    end

    saw_start = 1'b0;
    repeat (10) begin
      step();
      if (o_tx_start) saw_start = 1'b1;
    end
    check("idle_busy", int'(o_busy), 0);
    check("idle_oe_n", int'(o_oe_n), 1);
    check("idle_no_start", int'(saw_start), 0);

    // Base 0 behaves as 1; reset lands mid-DISPLAY on row 1, bit plane 2.
    i_base_time = 8'd0;
    i_enable = 1'b1;
    push_frame(0);
    for (int s = 0; s < c_bpp + 2; s++) run_slot();
    wait_start(e);
    wait_oe(e);
    step();
    check("mid_display_oe", int'(o_oe_n), 0);
    rst_n = 1'b0;
    step();
    check("rst_mid_oe_n", int'(o_oe_n), 1);
    check("rst_mid_tx_start", int'(o_tx_start), 0);
    check("rst_mid_init_addr", int'(o_init_addr), 0);
    check("rst_mid_pix_bit", int'(o_pix_bit), 0);
    check("rst_mid_row_addr", int'(o_row_addr), 0);
    check("rst_mid_frame_done", int'(o_frame_done), 0);
    check("rst_mid_busy", int'(o_busy), 0);
    i_enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_busy", int'(o_busy), 0);
    q.delete();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter hpixel_p, default 64, display width in pixels.
REQ-002 Parameter vpixel_p, default 64, display height in pixels.
REQ-003 Parameter bpp_p, default 8, bits per colour channel, i.e. the number of bit planes.
REQ-004 Parameter segments_p, default 2, number of panel segments driven in parallel.
REQ-005 Parameter blank_p, default 2, number of blanking cycles before output enable is asserted.
REQ-006 Derived: rows_p = vpixel_p/segments_p; row_w = clog2(rows_p); addr_w = clog2(hpixel_p*vpixel_p); bit_w = clog2(bpp_p).
REQ-007 Clock and reset: clk, input, 1, clock; rst_n, input, 1, synchronous active-low reset.
REQ-008 i_enable, input, 1, run scanning.
REQ-009 i_base_time, input, 8, number of OE-active cycles for bit plane 0.
REQ-010 i_tx_ready, input, 1, ready signal from the colour shift transmitter; high means idle.
REQ-011 o_tx_start, output, 1, single-cycle start pulse to the transmitter.
REQ-012 o_init_addr, output, addr_w, first framebuffer address of the current row.
REQ-013 o_pix_bit, output, bit_w, bit plane to shift.
REQ-014 o_row_addr, output, row_w, panel row select lines A/B/C/D/E.
REQ-015 o_oe_n, output, 1, panel output enable, active-low.
REQ-016 o_frame_done, output, 1, single-cycle pulse at the end of each frame.
REQ-017 o_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, START, WAIT_ACK, WAIT_DONE, BLANK and DISPLAY.
REQ-019 IDLE: when i_enable=1 and i_tx_ready=1, the block SHALL sample i_base_time (a value of 0 is treated as 1), set row=0 and bit=0, and go to START.
REQ-020 START: the block SHALL drive o_tx_start=1 for exactly one cycle, with o_init_addr = row*hpixel_p and o_pix_bit = bit valid in that same cycle and held until the next START, then go to WAIT_ACK.
REQ-021 WAIT_ACK: the block SHALL wait for i_tx_ready=0, then go to WAIT_DONE.
REQ-022 WAIT_DONE: the block SHALL wait for i_tx_ready=1 (shift and latch complete), then update o_row_addr to row and go to BLANK.
REQ-023 o_oe_n SHALL be 1 in every state except DISPLAY, so a latch or row change never occurs while the panel is lit.
REQ-024 BLANK: the block SHALL hold for blank_p cycles, then go to DISPLAY.
REQ-025 DISPLAY: o_oe_n SHALL be 0 for exactly base<<bit cycles; the counter is 8+bpp_p-1 bits wide with no overflow.
REQ-026 On DISPLAY expiry, if bit < bpp_p-1, the block SHALL increment bit and go to START.
REQ-027 On DISPLAY expiry with bit = bpp_p-1, the block SHALL set bit=0 and increment row.
REQ-028 Frame end: when row = rows_p-1 and bit = bpp_p-1 expire, row SHALL wrap to 0 and o_frame_done SHALL pulse for 1 cycle.
REQ-029 At frame end, if i_enable=1 the block SHALL resample i_base_time and go to START; otherwise it SHALL go to IDLE.
REQ-030 Deasserting i_enable mid-frame SHALL NOT abort the frame; the current frame completes first.
REQ-031 A change of i_base_time mid-frame SHALL be ignored until the next frame boundary.
REQ-032 If o_tx_start and i_tx_ready=0 occur in the same cycle, i_tx_ready=0 SHALL be ignored; acknowledgement is only checked from the cycle after the pulse.

Reset
REQ-033 While rst_n=0 at a clk edge, the block SHALL set: state=IDLE, o_tx_start=0, o_init_addr=0, o_pix_bit=0, o_row_addr=0, o_oe_n=1, o_frame_done=0, o_busy=0, and all counters to 0.
REQ-034 Reset asserted mid-DISPLAY SHALL force o_oe_n=1 at the next edge.

Structure
REQ-035 Package hub75_pkg SHALL hold the scan state enum and the derived-width helper constants (rows_p, row_w, addr_w, bit_w).
REQ-036 The block SHALL instantiate one sub-module, hub75_oe_timer: a loadable down-counter with load value base<<bit and a done pulse; all other logic is inline in the FSM.

Verification (hpixel=64, vpixel=64, bpp=8, segments=2; transmitter model drops ready 1 cycle after start and raises it 20 cycles later)
REQ-037 Bench SHALL check: reset release with i_enable=1 and base=4 -> first o_tx_start with addr=0 and bit=0; o_oe_n low for 4 cycles after 2 blank cycles.
REQ-038 Bench SHALL check: bit 7 of row 0 -> o_oe_n low for exactly 512 cycles.
REQ-039 Bench SHALL check: row 5 start -> o_init_addr=320 and o_row_addr=5, with o_row_addr changing only while o_oe_n=1.
REQ-040 Bench SHALL check: last row 31, bit 7 expiry -> one-cycle o_frame_done, then row=0, o_init_addr=0, and a new o_tx_start.
REQ-041 Bench SHALL check: i_enable dropped at row 10 -> frame completes, then IDLE with o_busy=0 and o_oe_n=1; base=0 -> 1-cycle OE at bit 0.
REQ-042 Bench SHALL check: rst_n asserted mid-DISPLAY -> o_oe_n=1 and all outputs at reset values on the next edge.
